sign_mag_bcd: RTL

SIGN_MAG_BCD -- requirements
Module: sign_mag_bcd

---
 rtl/sign_mag_bcd_pkg.sv | 16 +
 rtl/sign_mag_bcd_adj3.sv | 15 +
 rtl/sign_mag_bcd.sv | 116 +++++++++++
 3 files changed

// File: rtl/sign_mag_bcd_pkg.sv
// Shared types and constants for the sign-magnitude to BCD converter.
// Holds the FSM state encoding, digit count and the widest legal word.
package sign_mag_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NUM_DIGITS = 4;
    localparam int MAX_N      = 14;
    localparam int CNT_W      = $clog2(MAX_N);
    localparam int BCD_W      = 4 * NUM_DIGITS;

endpackage

// File: rtl/sign_mag_bcd_adj3.sv
// Double-dabble digit correction: adds 3 to a BCD digit greater than 4.
// Ports: din (4-bit digit in), dout (corrected digit out).
module bcd_adj3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din > 4'd4) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/sign_mag_bcd.sv
// Sequential sign-magnitude to BCD converter (double dabble, 1 bit/cycle).
// Ports: clk, reset, start, a[N-1:0] in; ready, done_tick, sign, bcd3..bcd0 out.
module sign_mag_bcd
    import sign_mag_bcd_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    output logic         ready,
    output logic         done_tick,
    output logic         sign,
    output logic [3:0]   bcd3,
    output logic [3:0]   bcd2,
    output logic [3:0]   bcd1,
    output logic [3:0]   bcd0
);

    localparam int MW = N - 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MW-1:0]      mag_q, mag_d;
    logic [BCD_W-1:0]   dig_q, dig_d;
    logic               sgn_cap_q, sgn_cap_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               sign_q, sign_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   dig_adj;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        bcd_adj3 u_adj (
            .din  (dig_q[4*g +: 4]),
            .dout (dig_adj[4*g +: 4])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mag_d     = mag_q;
        dig_d     = dig_q;
        sgn_cap_d = sgn_cap_q;
        done_d    = 1'b0;
        sign_d    = sign_q;
        bcd_d     = bcd_q;
        unique case (state_q)
            IDLE: begin
                // ready_q is low in the done_tick cycle, so a start
                // coinciding with the previous result is not taken.
                if (start && ready_q) begin
                    mag_d     = a[MW-1:0];
                    sgn_cap_d = a[N-1];
                    cnt_d     = CNT_W'(MW);
                    dig_d     = '0;
                    state_d   = OP;
                end
            end
            OP: begin
                dig_d = {dig_adj[BCD_W-2:0], mag_q[MW-1]};
                mag_d = mag_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d = 1'b1;
                bcd_d  = dig_q;
                // Negative zero displays as plain zero.
                sign_d = sgn_cap_q && (dig_q != '0);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE) && !done_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mag_q     <= '0;
            dig_q     <= '0;
            sgn_cap_q <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            sign_q    <= 1'b0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mag_q     <= mag_d;
            dig_q     <= dig_d;
            sgn_cap_q <= sgn_cap_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            sign_q    <= sign_d;
            bcd_q     <= bcd_d;
        end
    end

    assign ready     = ready_q;
    assign done_tick = done_q;
    assign sign      = sign_q;
    assign bcd3      = bcd_q[15:12];
    assign bcd2      = bcd_q[11:8];
    assign bcd1      = bcd_q[7:4];
    assign bcd0      = bcd_q[3:0];

endmodule
